// File: rtl/stage_cordic_prescale_hs_pkg.sv
// stage_cordic_prescale_hs_pkg: angle encoding, gain defaults and sideband layout shared by the prescale stage.
package stage_cordic_prescale_hs_pkg;

    localparam int ANGLE_W_DEF   = 9;
    localparam int QUARTER       = 1 << (ANGLE_W_DEF - 2);
    localparam int GAIN_K_DEF    = 155;
    localparam int GAIN_FRAC_DEF = 8;

    typedef enum logic [1:0] {
        QUAD_0   = 2'b00,
        QUAD_90  = 2'b01,
        QUAD_180 = 2'b10,
        QUAD_270 = 2'b11
    } quad_t;

    localparam int FORM_W     = 4;
    localparam int REF_W      = 8;
    localparam int PIX_W      = 8;
    localparam int COLOR_W    = 12;
    localparam int SIDE_W_DEF = FORM_W + 2 * REF_W + 2 * PIX_W + COLOR_W;

    typedef struct packed {
        logic [FORM_W-1:0]  form;
        logic [REF_W-1:0]   ref_y;
        logic [REF_W-1:0]   ref_x;
        logic [PIX_W-1:0]   pixel_y;
        logic [PIX_W-1:0]   pixel_x;
        logic [COLOR_W-1:0] color;
    } side_t;

    function automatic logic [SIDE_W_DEF-1:0] side_pack(
        input logic [FORM_W-1:0]  form,
        input logic [REF_W-1:0]   ref_y,
        input logic [REF_W-1:0]   ref_x,
        input logic [PIX_W-1:0]   pixel_y,
        input logic [PIX_W-1:0]   pixel_x,
        input logic [COLOR_W-1:0] color
    );
        return {form, ref_y, ref_x, pixel_y, pixel_x, color};
    endfunction

    function automatic side_t side_unpack(input logic [SIDE_W_DEF-1:0] v);
        return side_t'(v);
    endfunction

endpackage

// File: rtl/stage_cordic_prescale_hs_if.sv
// stage_cordic_prescale_hs_if: input token and output vector handshake bundle of the prescale stage.
interface stage_cordic_prescale_hs_if #(
    parameter int SIZE_W  = 7,
    parameter int ANGLE_W = 9,
    parameter int COORD_W = 19,
    parameter int SIDE_W  = 48
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_bubble;
    logic [SIZE_W-1:0]         in_size;
    logic signed [ANGLE_W-1:0] in_angle;
    logic [SIDE_W-1:0]         in_side;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_bubble;
    logic signed [COORD_W-1:0] cord_x;
    logic signed [COORD_W-1:0] cord_y;
    logic                      enable_cordic;
    logic signed [ANGLE_W-1:0] out_angle;
    logic [SIDE_W-1:0]         out_side;

    modport slave (
        input  in_valid, in_bubble, in_size, in_angle, in_side, out_ready,
        output in_ready, out_valid, out_bubble, cord_x, cord_y, enable_cordic, out_angle, out_side
    );

    modport master (
        output in_valid, in_bubble, in_size, in_angle, in_side, out_ready,
        input  in_ready, out_valid, out_bubble, cord_x, cord_y, enable_cordic, out_angle, out_side
    );
endinterface

// File: rtl/stage_cordic_prescale_hs_quadrant_map.sv
// stage_cordic_prescale_hs_quadrant_map: places a non-negative magnitude on the axis selected by the quadrant.
module stage_cordic_prescale_hs_quadrant_map
    import stage_cordic_prescale_hs_pkg::*;
#(
    parameter int MAG_W   = 18,
    parameter int COORD_W = 19
) (
    input  quad_t                     quad,
    input  logic [MAG_W-1:0]          mag,
    output logic signed [COORD_W-1:0] x,
    output logic signed [COORD_W-1:0] y
);
    logic signed [COORD_W-1:0] m;

    assign m = COORD_W'(mag);
    assign x = quad == QUAD_0  ? m : quad == QUAD_180 ? -m : '0;
    assign y = quad == QUAD_90 ? m : quad == QUAD_270 ? -m : '0;
endmodule

// File: rtl/stage_cordic_prescale_hs.sv
// stage_cordic_prescale_hs: two-stage valid/ready pipe building the gain-compensated initial CORDIC vector.
module stage_cordic_prescale_hs
    import stage_cordic_prescale_hs_pkg::*;
#(
    parameter int SIZE_W    = 7,
    parameter int FRAC_W    = 8,
    parameter int COORD_W   = 19,
    parameter int ANGLE_W   = ANGLE_W_DEF,
    parameter int GAIN_K    = GAIN_K_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF,
    parameter int SIDE_W    = SIDE_W_DEF,
    parameter bit QUAD_EN   = 1'b1
) (
    input logic                     clk,
    input logic                     reset,
    stage_cordic_prescale_hs_if.slave io
);
    localparam int GAIN_W = $clog2(GAIN_K + 1);
    localparam int PROD_W = SIZE_W + FRAC_W + GAIN_W;
    localparam int MAG_W  = COORD_W - 1;
    localparam int RES_W  = ANGLE_W - 2;

    logic                      s1_valid;
    logic                      s1_bubble;
    quad_t                     s1_quad;
    logic [RES_W-1:0]          s1_res;
    logic                      s1_en;
    logic [MAG_W-1:0]          s1_mag;
    logic signed [ANGLE_W-1:0] s1_angle;
    logic [SIDE_W-1:0]         s1_side;
    logic                      s1_adv, s2_adv, in_en;
    logic [PROD_W-1:0]         base, prod, mag_n;
    logic signed [COORD_W-1:0] qx, qy;

    assign s2_adv      = ~io.out_valid | io.out_ready;
    assign s1_adv      = ~s1_valid | s2_adv;
    assign io.in_ready = s1_adv;

    // Gain only matters when iterations run; an exact axis angle keeps the raw magnitude.
    assign in_en = |io.in_angle[RES_W-1:0];
    assign base  = PROD_W'(io.in_size) << FRAC_W;
    assign prod  = base * PROD_W'(GAIN_K);
    assign mag_n = in_en ? prod >> GAIN_FRAC : base;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_bubble <= 1'b0;
            s1_quad   <= QUAD_0;
            s1_res    <= '0;
            s1_en     <= 1'b0;
            s1_mag    <= '0;
            s1_angle  <= '0;
            s1_side   <= '0;
        end else if (s1_adv) begin
            s1_valid  <= io.in_valid;
            s1_bubble <= io.in_bubble;
            s1_quad   <= quad_t'(io.in_angle[ANGLE_W-1 -: 2]);
            s1_res    <= io.in_angle[RES_W-1:0];
            s1_en     <= in_en;
            s1_mag    <= MAG_W'(mag_n);
            s1_angle  <= io.in_angle;
            s1_side   <= io.in_side;
        end
    end

    stage_cordic_prescale_hs_quadrant_map #(
        .MAG_W   (MAG_W),
        .COORD_W (COORD_W)
    ) u_quad (
        .quad (s1_quad),
        .mag  (s1_mag),
        .x    (qx),
        .y    (qy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io.out_valid     <= 1'b0;
            io.out_bubble    <= 1'b0;
            io.cord_x        <= '0;
            io.cord_y        <= '0;
            io.enable_cordic <= 1'b0;
            io.out_angle     <= '0;
            io.out_side      <= '0;
        end else if (s2_adv) begin
            io.out_valid     <= s1_valid;
            io.out_bubble    <= s1_bubble;
            io.cord_x        <= QUAD_EN ? qx : COORD_W'(s1_mag);
            io.cord_y        <= QUAD_EN ? qy : '0;
            io.enable_cordic <= s1_en;
            io.out_angle     <= QUAD_EN ? ANGLE_W'(s1_res) : s1_angle;
            io.out_side      <= s1_side;
        end
    end
endmodule

// File: tb/tb_stage_cordic_prescale_hs.sv
// tb_stage_cordic_prescale_hs: directed and randomized checks of both prescale modes against an arithmetic reference.
module tb_stage_cordic_prescale_hs;
    import stage_cordic_prescale_hs_pkg::*;

    localparam int SIZE_W  = 7;
    localparam int ANGLE_W = 9;
    localparam int COORD_W = 19;
    localparam int SIDE_W  = 48;

    typedef struct {
        bit                bubble;
        logic [SIDE_W-1:0] side;
        int                x, y, mag, ang, ang0;
        bit                en;
    } tok_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    tok_t q[$];
    tok_t mon_e;

    always #5 clk = ~clk;

    stage_cordic_prescale_hs_if #(.SIZE_W(SIZE_W), .ANGLE_W(ANGLE_W), .COORD_W(COORD_W), .SIDE_W(SIDE_W)) bus ();
    stage_cordic_prescale_hs_if #(.SIZE_W(SIZE_W), .ANGLE_W(ANGLE_W), .COORD_W(COORD_W), .SIDE_W(SIDE_W)) bus_l ();

    stage_cordic_prescale_hs #(.QUAD_EN(1'b1)) dut (.clk(clk), .reset(reset), .io(bus));
    stage_cordic_prescale_hs #(.QUAD_EN(1'b0)) dut_l (.clk(clk), .reset(reset), .io(bus_l));

    assign bus_l.in_valid  = bus.in_valid;
    assign bus_l.in_bubble = bus.in_bubble;
    assign bus_l.in_size   = bus.in_size;
    assign bus_l.in_angle  = bus.in_angle;
    assign bus_l.in_side   = bus.in_side;
    assign bus_l.out_ready = bus.out_ready;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: angle wrapped to one turn of 512 units, quarter turns of 128.
    function automatic tok_t model(input bit b, input int size, input int angle, input logic [SIDE_W-1:0] side);
        tok_t m;
        int au, quad;
        au     = ((angle % 512) + 512) % 512;
        quad   = au / 128;
        m.ang  = au % 128;
        m.en   = m.ang != 0;
        m.mag  = m.en ? (size * 256 * 155) / 256 : size * 256;
        m.x    = quad == 0 ? m.mag : quad == 2 ? -m.mag : 0;
        m.y    = quad == 1 ? m.mag : quad == 3 ? -m.mag : 0;
        m.ang0 = angle;
        m.bubble = b;
        m.side = side;
        return m;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("unexpected_out", bus.out_valid, 0);
                else begin
                    mon_e = q.pop_front();
                    check("sb_bubble", bus.out_bubble, mon_e.bubble);
                    check("sb_side", bus.out_side, mon_e.side);
                    check("sb_x", $signed(bus.cord_x), mon_e.x);
                    check("sb_y", $signed(bus.cord_y), mon_e.y);
                    check("sb_angle", $signed(bus.out_angle), mon_e.ang);
                    check("sb_enable", bus.enable_cordic, mon_e.en);
                    check("sb_leg_valid", bus_l.out_valid, 1);
                    check("sb_leg_side", bus_l.out_side, mon_e.side);
                    check("sb_leg_x", $signed(bus_l.cord_x), mon_e.mag);
                    check("sb_leg_y", $signed(bus_l.cord_y), 0);
                    check("sb_leg_angle", $signed(bus_l.out_angle), mon_e.ang0);
                    check("sb_leg_enable", bus_l.enable_cordic, mon_e.en);
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_bubble, int'(bus.in_size), int'($signed(bus.in_angle)), bus.in_side));
        end
    end

    task automatic set_tok(input int k);
        bus.in_bubble = k[0];
        bus.in_size   = SIZE_W'(10 + k * 17);
        bus.in_angle  = ANGLE_W'(k * 50 - 120);
        bus.in_side   = side_pack(4'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3), 8'(k + 4), 12'(k * 99));
    endtask

    // size, angle, x, y, out_angle, enable, legacy x, legacy angle
    int dt[7][8] = '{
        '{100,    0, 25600,      0,   0, 0, 25600,    0},
        '{100,   45, 15500,      0,  45, 1, 15500,   45},
        '{127,  200,     0,  19685,  72, 1, 19685,  200},
        '{ 10,   -1,     0,  -1550, 127, 1,  1550,   -1},
        '{ 10, -256, -2560,      0,   0, 0,  2560, -256},
        '{100,  -56,     0, -15500,  72, 1, 15500,  -56},
        '{  0,   77,     0,      0,  77, 1,     0,   77}
    };

    initial begin
        int k, cyc;
        bit acc;
        bus.in_valid  = 1'b0;
        bus.in_bubble = 1'b0;
        bus.in_size   = '0;
        bus.in_angle  = '0;
        bus.in_side   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bubble", bus.out_bubble, 0);
        check("rst_cord_x", $signed(bus.cord_x), 0);
        check("rst_in_ready", bus.in_ready, 1);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_bubble = 1'b0;
            bus.in_size   = SIZE_W'(dt[i][0]);
            bus.in_angle  = ANGLE_W'(dt[i][1]);
            bus.in_side   = side_pack(4'(i), 8'd1, 8'd2, 8'd3, 8'd4, 12'(i + 5));
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("dir_lat1_valid", bus.out_valid, 0);
            @(posedge clk); #1;
            check("dir_valid", bus.out_valid, 1);
            check("dir_x", $signed(bus.cord_x), dt[i][2]);
            check("dir_y", $signed(bus.cord_y), dt[i][3]);
            check("dir_angle", $signed(bus.out_angle), dt[i][4]);
            check("dir_enable", bus.enable_cordic, dt[i][5]);
            check("dir_leg_x", $signed(bus_l.cord_x), dt[i][6]);
            check("dir_leg_y", $signed(bus_l.cord_y), 0);
            check("dir_leg_angle", $signed(bus_l.out_angle), dt[i][7]);
            check("dir_leg_enable", bus_l.enable_cordic, dt[i][5]);
        end
        @(posedge clk); #1;

        // Backpressure: out_ready low for four cycles while six tokens are offered.
        k = 0;
        cyc = 0;
        set_tok(0);
        bus.in_valid = 1'b1;
        while (k < 6 && cyc < 100) begin
            bus.out_ready = cyc >= 4;
            #1;
            if (cyc == 2 || cyc == 3) begin
                check("bp_full_in_ready", bus.in_ready, 0);
                check("bp_hold_valid", bus.out_valid, 1);
                check("bp_hold_side", bus.out_side, q[0].side);
            end
            if (cyc == 4) check("bp_ready_rise", bus.in_ready, 1);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 6) set_tok(k);
                else bus.in_valid = 1'b0;
            end
            cyc++;
        end
        check("bp_all_sent", k, 6);
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", q.size(), 0);

        // Reset while the pipe is full.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_bubble = 1'b1;
        bus.in_size   = 7'd50;
        bus.in_angle  = 9'sd30;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_full", bus.out_valid, 1);
        reset = 1'b0;
        #1;
        q.delete();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_bubble", bus.out_bubble, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bubble = 1'b0;
        bus.in_size   = 7'd33;
        bus.in_angle  = -9'sd100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("post_rst_lat1", bus.out_valid, 0);
        @(posedge clk); #1;
        check("post_rst_lat2", bus.out_valid, 1);
        @(posedge clk); #1;

        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_bubble = 1'($urandom);
            bus.in_size   = ($urandom % 8 == 0) ? '0 : SIZE_W'($urandom);
            bus.in_angle  = ($urandom % 8 == 0) ? -9'sd256 : ANGLE_W'($urandom);
            bus.in_side   = SIDE_W'({$urandom, $urandom});
            bus.out_ready = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("final_drained", q.size(), 0);
        check("final_idle", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
